// File: rtl/mos_switch_arbiter.sv
`default_nettype none
// mos_switch_arbiter: round-robin owner of a shared net through NMOS/PMOS pass pairs,
// with break-before-make dead time and a hold limit. Rev 1.0
module mos_switch_arbiter #(
  parameter int N           = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gate_n,
  output logic [N-1:0]         gate_p,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 hold_expired
);

  localparam int IW = $clog2(N);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEAD = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr;
  logic [IW-1:0] next_win;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          hexp;

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // First requester above ptr, wrapping; the previous owner is checked last.
  always_comb begin
    next_win = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        next_win = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      winner <= '0;
      ptr    <= IW'(N-1);
      dcnt   <= '0;
      hcnt   <= '0;
      hexp   <= 1'b0;
    end else begin
      hexp <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != '0) begin
            winner <= next_win;
            dcnt   <= '0;
            state  <= S_DEAD;
          end
        end
        S_DEAD: begin
          if (!req[winner]) begin
            state <= S_IDLE;
          end else if (dcnt == DW'(DEAD_CYCLES-1)) begin
            hcnt  <= '0;
            state <= S_ON;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_ON: begin
          if (!req[winner]) begin
            ptr   <= winner;
            state <= S_IDLE;
          end else if (hcnt == HW'(MAX_HOLD-1)) begin
            ptr   <= winner;
            hexp  <= 1'b1;
            state <= S_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gates are a pure decode of registered state, so no switch can close outside ON.
  always_comb begin
    gate_n = '0;
    if (state == S_ON) gate_n[winner] = 1'b1;
  end

  assign gate_p       = ~gate_n;
  assign grant_id     = winner;
  assign busy         = (state != S_IDLE);
  assign hold_expired = hexp;

endmodule
`default_nettype wire

// File: tb/tb_mos_switch_arbiter.sv
`default_nettype none
// tb_mos_switch_arbiter: directed stimulus, per-cycle comparison against a
// phase/timer model of the arbiter, plus literal checkpoints. Rev 1.0
module tb_mos_switch_arbiter;

  localparam int N           = 4;
  localparam int DEAD_CYCLES = 2;
  localparam int MAX_HOLD    = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N-1:0]         gate_n;
  logic [N-1:0]         gate_p;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic                 hold_expired;

  int checks = 0;
  int errors = 0;

  mos_switch_arbiter #(.N(N), .DEAD_CYCLES(DEAD_CYCLES), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .gate_n(gate_n), .gate_p(gate_p),
    .grant_id(grant_id), .busy(busy), .hold_expired(hold_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 = net free, 1 = waiting out the dead time, 2 = owner connected.
  int m_mode = 0;
  int m_win  = 0;
  int m_ptr  = N-1;
  int m_t    = 0;
  bit m_hexp = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  initial begin : compare
    logic [N-1:0] exp_gn;
    logic [N-1:0] inv_gn;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_win = 0; m_ptr = N-1; m_t = 0; m_hexp = 1'b0;
      end else begin
        m_hexp = 1'b0;
        case (m_mode)
          0: if (req != '0) begin
               m_win = rr_pick(req, m_ptr); m_mode = 1; m_t = 0;
             end
          1: if (!req[m_win]) m_mode = 0;
             else begin
               m_t++;
               if (m_t == DEAD_CYCLES) begin m_mode = 2; m_t = 0; end
             end
          default: if (!req[m_win]) begin m_mode = 0; m_ptr = m_win; end
             else begin
               m_t++;
               if (m_t == MAX_HOLD) begin m_mode = 0; m_ptr = m_win; m_hexp = 1'b1; end
             end
        endcase
      end
      @(negedge clk);
      exp_gn = '0;
      if (m_mode == 2) exp_gn[m_win] = 1'b1;
      inv_gn = ~gate_n;
      chk("gate_n", 32'(gate_n), 32'(exp_gn));
      chk("gate_p_compl", 32'(gate_p), 32'(inv_gn));
      chk("onehot0", 32'($countones(gate_n) <= 1), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(m_win));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("hold_expired", 32'(hold_expired), 32'(m_hexp));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst = 1'b1;
    req = 4'b1111;
    tick(2);
    chk("rst_gate_n", 32'(gate_n), 32'h0);
    chk("rst_gate_p", 32'(gate_p), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    rst = 1'b0;

    // Full contention: 0,1,2,3,0 with 8-cycle holds and 3-cycle gaps.
    tick(3);  chk("cont_g0", 32'(gate_n), 32'h1);
    tick(8);  chk("cont_gap0", 32'(gate_n), 32'h0);
              chk("cont_hexp0", 32'(hold_expired), 32'h1);
    tick(3);  chk("cont_g1", 32'(gate_n), 32'h2);
    tick(11); chk("cont_g2", 32'(gate_n), 32'h4);
    tick(11); chk("cont_g3", 32'(gate_n), 32'h8);
    tick(11); chk("cont_g0b", 32'(gate_n), 32'h1);
    req = 4'b0000;
    tick(1);  chk("drop_gate_n", 32'(gate_n), 32'h0);
              chk("drop_no_hexp", 32'(hold_expired), 32'h0);

    // Early release: requester 1 then 3.
    req = 4'b1010;
    tick(3);  chk("early_g1", 32'(gate_n), 32'h2);
    tick(2);
    req = 4'b1000;
    tick(1);  chk("early_open", 32'(gate_n), 32'h0);
              chk("early_no_hexp", 32'(hold_expired), 32'h0);
    tick(3);  chk("early_g3", 32'(gate_n), 32'h8);
    req = 4'b0000;
    tick(1);

    // Single holder expiry and same-requester re-grant.
    req = 4'b0100;
    tick(2);  chk("single_dead", 32'(gate_n), 32'h0);
    tick(1);  chk("single_on", 32'(gate_n), 32'h4);
    tick(7);  chk("single_last", 32'(gate_n), 32'h4);
    tick(1);  chk("single_open", 32'(gate_n), 32'h0);
              chk("single_hexp", 32'(hold_expired), 32'h1);
    tick(1);  chk("single_hexp_off", 32'(hold_expired), 32'h0);
    tick(1);  chk("single_gap", 32'(gate_n), 32'h0);
    tick(1);  chk("single_regrant", 32'(gate_n), 32'h4);
    req = 4'b0000;
    tick(2);

    // DEAD abort leaves ptr at 2, so 0011 picks requester 0.
    req = 4'b0001;
    tick(1);  chk("abort_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick(1);  chk("abort_idle", 32'(busy), 32'h0);
              chk("abort_gate_n", 32'(gate_n), 32'h0);
    req = 4'b0011;
    tick(3);  chk("abort_ptr", 32'(gate_n), 32'h1);

    // Reset while requester 1 is connected.
    req = 4'b0010;
    tick(1);  chk("pre_rst_open", 32'(gate_n), 32'h0);
    tick(3);  chk("pre_rst_g1", 32'(gate_n), 32'h2);
    tick(2);
    rst = 1'b1;
    tick(1);  chk("mid_rst_gate_n", 32'(gate_n), 32'h0);
              chk("mid_rst_gate_p", 32'(gate_p), 32'hF);
              chk("mid_rst_hexp", 32'(hold_expired), 32'h0);
    rst = 1'b0;
    req = 4'b0011;
    tick(3);  chk("post_rst_g0", 32'(gate_n), 32'h1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mos_switch_arbiter.md
# mos_switch_arbiter

Round-robin arbiter and sequencer for a shared output net driven through per-requester NMOS/PMOS pass-switch pairs. The block grants the net to one requester at a time and drives the complementary gate controls of that requester's switch pair. It enforces break-before-make dead time so no two switches ever conduct together, and a maximum hold time so no requester starves the others. It sits between the requester control logic and the pass-switch array.

## Interface
- N, default 4: number of requesters/switch pairs (2..16).
- DEAD_CYCLES, default 2: cycles all switches are off in DEAD before a new switch closes (>=1).
- MAX_HOLD, default 8: maximum consecutive ON cycles per grant (>=1).

- clk  input  1  the only clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester level request; held high while the net is wanted.
- gate_n  output  N  NMOS gate controls; bit i high closes requester i's NMOS.
- gate_p  output  N  PMOS gate controls; bit i low closes requester i's PMOS; always equals ~gate_n.
- grant_id  output  $clog2(N)  index of the current or pending winner.
- busy  output  1  high whenever state != IDLE.
- hold_expired  output  1  one-cycle pulse when a grant ends because MAX_HOLD was reached.

## Operation
- FSM states: IDLE, DEAD, ON. All outputs are decoded from registered state, winner, and flags.
- IDLE: all switches open. If req != 0, latch the winner as the first set bit of req searching from ptr+1 upward, wrapping modulo N. Clear dcnt and go to DEAD.
- DEAD: all switches open; dcnt increments each cycle.
  - If req[winner]==0 at an edge, abort to IDLE. No grant occurs and ptr is unchanged.
  - Otherwise, at dcnt==DEAD_CYCLES-1, clear hcnt and go to ON.
- ON: gate_n[winner]=1, gate_p[winner]=0; all other bits open. hcnt increments each cycle.
  - If req[winner]==0, go to IDLE.
  - Else if hcnt==MAX_HOLD-1, go to IDLE and assert hold_expired for the following cycle.
  - On either exit, ptr <= winner.
- Invariants:
  - gate_n is zero or one-hot.
  - gate_p == ~gate_n on every cycle.
  - gate_n is never nonzero outside ON.
- Round-robin: the last-granted requester has lowest priority at the next arbitration.
- Reset values:
  - state=IDLE; gate_n=0; gate_p=all ones; grant_id=0; busy=0; hold_expired=0.
  - ptr=N-1, so requester 0 has first priority.
  - dcnt=0; hcnt=0.
- Reset mid-operation (any state): at the next edge all switches open and all state returns to reset values; no hold_expired pulse.
- Counter widths: dcnt is sized for DEAD_CYCLES-1 and hcnt for MAX_HOLD-1; neither counter wraps.

## Timing
- req edge-sampled in IDLE at edge k → gate closes after edge k+DEAD_CYCLES (latency DEAD_CYCLES+1 cycles from the sampling cycle).
- Maximum ON duration is MAX_HOLD cycles. The switch opens at the edge where the drop or expiry is sampled.
- Minimum open gap between two grants is DEAD_CYCLES+1 cycles: one IDLE cycle plus DEAD. This applies even when re-granting the same requester.
- busy rises after the IDLE→DEAD edge and falls after the ON→IDLE or DEAD→IDLE edge.
- grant_id updates on the IDLE→DEAD edge and is stable through DEAD and ON.
- hold_expired is high only in the first IDLE cycle after an expiry exit.

## Test plan
- Reset check:
  - Stimulus: rst high 2 cycles, req=4'b1111.
  - Response: gate_n=0000, gate_p=1111, busy=0, grant_id=0 throughout; after release, requester 0 is granted first.
- Single holder expiry:
  - Stimulus: req=4'b0100 held.
  - Response: gate_n=0100 closes 3 cycles after the first sample, stays 8 cycles, then 0000 for 3 cycles with a hold_expired pulse, then 0100 again.
- Full contention:
  - Stimulus: req=4'b1111 held.
  - Response: grant order 0,1,2,3,0; each ON for 8 cycles with 3-cycle gaps; gate_n is never multi-hot and gate_p==~gate_n on every cycle.
- Early release:
  - Stimulus: req=4'b1010; requester 1 granted; req[1] drops on the 3rd ON cycle.
  - Response: gate_n→0000 at the next edge; no hold_expired; gate_n=1000 three cycles later.
- DEAD abort:
  - Stimulus: single-cycle req[0] pulse from IDLE.
  - Response: busy high for 1-2 cycles; gate_n stays 0000; ptr unchanged, so a later req=4'b0011 grants requester 0.
- Reset during ON:
  - Stimulus: rst asserted while gate_n=0010.
  - Response: gate_n=0000 and gate_p=1111 after that edge; after release with req=4'b0011, requester 0 wins.
